// File: rtl/multi_ch_pulse_gen.sv
// multi_ch_pulse_gen
//   NUM_CH independent pulse generators. Each channel is programmed through a
//   shared config port with phase delay, high time, low time and pulse count
//   (count 0 = run until stopped). Each channel is then started or aborted by
//   its own strobe.
//
// Ports
//   clk, rst          single rising-edge clock, synchronous active-high reset
//   cfg_valid/ready   config handshake: a transfer happens on any rising edge
//                     where cfg_valid && cfg_ready. cfg_ready depends only on
//                     cfg_ch and channel state, never on cfg_valid. Fields
//                     must stay stable while cfg_valid is high and no
//                     transfer has happened.
//   cfg_ch            target channel; out-of-range values are never accepted
//   cfg_phase/high/low/npuls  timing fields for the target channel
//   start, stop       per-channel strobes; stop has priority over start
//   sig               registered waveform outputs, high only in HIGH
//   busy              channel not IDLE
//   done              one-cycle pulse when a finite sequence completes
//   cyc_cnt           free-running 32-bit cycle counter
//   dbg_state         per-channel FSM state, 2 bits per channel
module multi_ch_pulse_gen #(
  parameter int NUM_CH  = 3,
  parameter int CNT_W   = 8,
  parameter int NPULS_W = 8,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [CNT_W-1:0]      cfg_phase,
  input  logic [CNT_W-1:0]      cfg_high,
  input  logic [CNT_W-1:0]      cfg_low,
  input  logic [NPULS_W-1:0]    cfg_npuls,
  input  logic [NUM_CH-1:0]     start,
  input  logic [NUM_CH-1:0]     stop,
  output logic [NUM_CH-1:0]     sig,
  output logic [NUM_CH-1:0]     busy,
  output logic [NUM_CH-1:0]     done,
  output logic [31:0]           cyc_cnt,
  output logic [2*NUM_CH-1:0]   dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PHASE = 2'd1;
  localparam logic [1:0] S_HIGH  = 2'd2;
  localparam logic [1:0] S_LOW   = 2'd3;

  // Programmed configuration, one set per channel
  logic [CNT_W-1:0]   phase_q [NUM_CH];
  logic [CNT_W-1:0]   phase_d [NUM_CH];
  logic [CNT_W-1:0]   high_q  [NUM_CH];
  logic [CNT_W-1:0]   high_d  [NUM_CH];
  logic [CNT_W-1:0]   low_q   [NUM_CH];
  logic [CNT_W-1:0]   low_d   [NUM_CH];
  logic [NPULS_W-1:0] npuls_q [NUM_CH];
  logic [NPULS_W-1:0] npuls_d [NUM_CH];

  // Run-time copies taken at start, so a config accepted on the same edge
  // as a start only affects the next run.
  logic [CNT_W-1:0]   hm1_q  [NUM_CH];
  logic [CNT_W-1:0]   hm1_d  [NUM_CH];
  logic [CNT_W-1:0]   lm1_q  [NUM_CH];
  logic [CNT_W-1:0]   lm1_d  [NUM_CH];
  logic [NPULS_W-1:0] left_q [NUM_CH];
  logic [NPULS_W-1:0] left_d [NUM_CH];
  logic               inf_q  [NUM_CH];
  logic               inf_d  [NUM_CH];

  logic [1:0]         state_q [NUM_CH];
  logic [1:0]         state_d [NUM_CH];
  logic [CNT_W-1:0]   cnt_q   [NUM_CH];
  logic [CNT_W-1:0]   cnt_d   [NUM_CH];

  logic [NUM_CH-1:0]  sig_q, sig_d, done_q, done_d;
  logic [31:0]        cyc_q;

  // Durations are loaded as (length - 1) and counted down to zero; a zero
  // field is treated as a length of one.
  function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  always_comb begin
    cfg_ready = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = (state_q[i] == S_IDLE);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      phase_d[i] = phase_q[i];
      high_d[i]  = high_q[i];
      low_d[i]   = low_q[i];
      npuls_d[i] = npuls_q[i];
      hm1_d[i]   = hm1_q[i];
      lm1_d[i]   = lm1_q[i];
      left_d[i]  = left_q[i];
      inf_d[i]   = inf_q[i];
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      done_d[i]  = 1'b0;

      if (cfg_valid && cfg_ready && (cfg_ch == CH_W'(i))) begin
        phase_d[i] = cfg_phase;
        high_d[i]  = cfg_high;
        low_d[i]   = cfg_low;
        npuls_d[i] = cfg_npuls;
      end

      case (state_q[i])
        S_IDLE: begin
          if (start[i]) begin
            hm1_d[i]  = len_m1(high_q[i]);
            lm1_d[i]  = len_m1(low_q[i]);
            left_d[i] = npuls_q[i];
            inf_d[i]  = (npuls_q[i] == '0);
            if (phase_q[i] != '0) begin
              state_d[i] = S_PHASE;
              cnt_d[i]   = phase_q[i] - CNT_W'(1);
            end else begin
              state_d[i] = S_HIGH;
              cnt_d[i]   = len_m1(high_q[i]);
            end
          end
        end
        S_PHASE: begin
          if (cnt_q[i] == '0) begin
            state_d[i] = S_HIGH;
            cnt_d[i]   = hm1_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
          end
        end
        S_HIGH: begin
          if (cnt_q[i] == '0) begin
            state_d[i] = S_LOW;
            cnt_d[i]   = lm1_q[i];
            if (!inf_q[i]) left_d[i] = left_q[i] - NPULS_W'(1);
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
          end
        end
        default: begin // S_LOW
          if (cnt_q[i] == '0) begin
            // The last pulse still gets its full low time before finishing.
            if (!inf_q[i] && (left_q[i] == '0)) begin
              state_d[i] = S_IDLE;
              done_d[i]  = 1'b1;
            end else begin
              state_d[i] = S_HIGH;
              cnt_d[i]   = hm1_q[i];
            end
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
          end
        end
      endcase

      if (stop[i]) begin
        state_d[i] = S_IDLE;
        cnt_d[i]   = '0;
        done_d[i]  = 1'b0;
      end

      sig_d[i] = (state_d[i] == S_HIGH);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        phase_q[i] <= '0;
        high_q[i]  <= '0;
        low_q[i]   <= '0;
        npuls_q[i] <= '0;
        hm1_q[i]   <= '0;
        lm1_q[i]   <= '0;
        left_q[i]  <= '0;
        inf_q[i]   <= 1'b0;
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
      end
      sig_q  <= '0;
      done_q <= '0;
      cyc_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        phase_q[i] <= phase_d[i];
        high_q[i]  <= high_d[i];
        low_q[i]   <= low_d[i];
        npuls_q[i] <= npuls_d[i];
        hm1_q[i]   <= hm1_d[i];
        lm1_q[i]   <= lm1_d[i];
        left_q[i]  <= left_d[i];
        inf_q[i]   <= inf_d[i];
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      sig_q  <= sig_d;
      done_q <= done_d;
      cyc_q  <= cyc_q + 32'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      busy[i]             = (state_q[i] != S_IDLE);
      dbg_state[2*i +: 2] = state_q[i];
    end
  end

  assign sig     = sig_q;
  assign done    = done_q;
  assign cyc_cnt = cyc_q;

endmodule
